// File: rtl/bus_mux_pkg.sv
// Shared constants for the A/B bus source selector: mode encodings and default geometry.
package bus_mux_pkg;

    localparam int unsigned DEF_DATA_W  = 16;
    localparam int unsigned DEF_SEL_W   = 5;
    localparam int unsigned DEF_NUM_SRC = 32;

    // Populated slots 1-15 and 18-21; slot 0 is never a source
    localparam logic [31:0] DEF_SRC_MASK = 32'h003C_FFFE;

    localparam logic [1:0] MODE_HOLD = 2'd0;
    localparam logic [1:0] MODE_RG1  = 2'd1;
    localparam logic [1:0] MODE_MD   = 2'd2;
    localparam logic [1:0] MODE_RG2  = 2'd3;

endpackage

// File: rtl/bus_mux_sel_decode.sv
// Combinational selector decode: picks the slot index from the active selector field
// and flags whether a load is requested and whether the slot is populated.
module bus_mux_sel_decode
    import bus_mux_pkg::*;
#(
    parameter int unsigned        NUM_SRC  = DEF_NUM_SRC,
    parameter int unsigned        SEL_W    = DEF_SEL_W,
    parameter logic [NUM_SRC-1:0] SRC_MASK = NUM_SRC'(DEF_SRC_MASK)
) (
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel_rg1,
    input  logic [SEL_W-1:0] sel_md,
    input  logic [SEL_W-1:0] sel_rg2,
    output logic [SEL_W-1:0] idx_c,
    output logic             load_req_c,
    output logic             legal_c
);

    // Mask widened to the full selector range; slots at or above NUM_SRC read as unpopulated
    localparam int unsigned       MASK_W   = 1 << SEL_W;
    localparam logic [MASK_W-1:0] MASK_EXT = MASK_W'(SRC_MASK);

    always_comb begin
        idx_c      = '0;
        load_req_c = 1'b0;
        legal_c    = 1'b0;
        case (mode)
            MODE_RG1: idx_c = sel_rg1;
            MODE_MD:  idx_c = sel_md;
            MODE_RG2: idx_c = sel_rg2;
            default:  idx_c = '0;
        endcase
        load_req_c = (mode != MODE_HOLD);
        legal_c    = load_req_c && MASK_EXT[idx_c];
    end

endmodule

// File: rtl/bus_src_mux_p.sv
// Registered A/B bus source selector with stall, write-back forwarding and sticky select error.
// Define BUS_MUX_PIPE_EN to add a second register stage (load latency 2).
module bus_src_mux_p
    import bus_mux_pkg::*;
#(
    parameter int unsigned        DATA_W   = DEF_DATA_W,
    parameter int unsigned        NUM_SRC  = DEF_NUM_SRC,
    parameter int unsigned        SEL_W    = DEF_SEL_W,
    parameter logic [NUM_SRC-1:0] SRC_MASK = NUM_SRC'(DEF_SRC_MASK)
) (
    input  logic                      Clock,
    input  logic                      Reset_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel_rg1,
    input  logic [SEL_W-1:0]          sel_md,
    input  logic [SEL_W-1:0]          sel_rg2,
    input  logic                      stall,
    input  logic                      wb_en,
    input  logic [SEL_W-1:0]          wb_idx,
    input  logic [DATA_W-1:0]         wb_data,
    input  logic                      err_clr,
    output logic [DATA_W-1:0]         bus_data,
    output logic                      bus_valid,
    output logic [SEL_W-1:0]          bus_src,
    output logic                      sel_err
);

    logic [SEL_W-1:0]  idx_c;
    logic              load_req_c;
    logic              legal_c;
    logic [DATA_W-1:0] slot_c;
    logic [DATA_W-1:0] fwd_c;
    logic              err_set_c;

    logic [DATA_W-1:0] s1_data;
    logic [SEL_W-1:0]  s1_src;
    logic              s1_valid;

    bus_mux_sel_decode #(
        .NUM_SRC  (NUM_SRC),
        .SEL_W    (SEL_W),
        .SRC_MASK (SRC_MASK)
    ) u_decode (
        .mode       (mode),
        .sel_rg1    (sel_rg1),
        .sel_md     (sel_md),
        .sel_rg2    (sel_rg2),
        .idx_c      (idx_c),
        .load_req_c (load_req_c),
        .legal_c    (legal_c)
    );

    // Slot read, then a same-cycle write-back to the chosen slot overrides the stale value
    always_comb begin
        slot_c = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (idx_c == SEL_W'(i)) begin
                slot_c = src_data[i*DATA_W +: DATA_W];
            end
        end
        fwd_c = (wb_en && (wb_idx == idx_c)) ? wb_data : slot_c;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            s1_data  <= '0;
            s1_src   <= '0;
            s1_valid <= 1'b0;
        end else if (!stall) begin
            s1_valid <= legal_c;
            if (legal_c) begin
                s1_data <= fwd_c;
                s1_src  <= idx_c;
            end
        end
    end

`ifdef BUS_MUX_PIPE_EN
    logic s1_err;

    // Second stage carries data, source, strobe and error-set together; no re-forwarding here
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            s1_err    <= 1'b0;
            bus_data  <= '0;
            bus_src   <= '0;
            bus_valid <= 1'b0;
        end else if (!stall) begin
            s1_err    <= load_req_c && !legal_c;
            bus_valid <= s1_valid;
            if (s1_valid) begin
                bus_data <= s1_data;
                bus_src  <= s1_src;
            end
        end
    end

    assign err_set_c = s1_err;
`else
    assign bus_data  = s1_data;
    assign bus_src   = s1_src;
    assign bus_valid = s1_valid;
    assign err_set_c = load_req_c && !legal_c;
`endif

    // Sticky error: a new illegal select wins over a simultaneous clear
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            sel_err <= 1'b0;
        end else if (!stall) begin
            if (err_set_c) begin
                sel_err <= 1'b1;
            end else if (err_clr) begin
                sel_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_src_mux_p.sv
// Scoreboard bench for bus_src_mux_p: directed rows push the expected post-edge outputs,
// a monitor pops and compares one entry per clock edge.
module tb_bus_src_mux_p;

    localparam int unsigned DW = 16;
    localparam int unsigned NS = 32;
    localparam int unsigned SW = 5;

    typedef struct {
        logic [DW-1:0] data;
        logic          valid;
        logic [SW-1:0] src;
        logic          err;
    } exp_t;

    logic             Clock;
    logic             Reset_n;
    logic [NS*DW-1:0] src_data;
    logic [1:0]       mode;
    logic [SW-1:0]    sel_rg1;
    logic [SW-1:0]    sel_md;
    logic [SW-1:0]    sel_rg2;
    logic             stall;
    logic             wb_en;
    logic [SW-1:0]    wb_idx;
    logic [DW-1:0]    wb_data;
    logic             err_clr;
    logic [DW-1:0]    bus_data;
    logic             bus_valid;
    logic [SW-1:0]    bus_src;
    logic             sel_err;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    bus_src_mux_p dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .src_data  (src_data),
        .mode      (mode),
        .sel_rg1   (sel_rg1),
        .sel_md    (sel_md),
        .sel_rg2   (sel_rg2),
        .stall     (stall),
        .wb_en     (wb_en),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .err_clr   (err_clr),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .bus_src   (bus_src),
        .sel_err   (sel_err)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented every edge, compared just after it
    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("bus_data",  32'(bus_data),  32'(e.data));
                chk("bus_valid", 32'(bus_valid), 32'(e.valid));
                chk("bus_src",   32'(bus_src),   32'(e.src));
                chk("sel_err",   32'(sel_err),   32'(e.err));
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] m, input int a, input int b, input int c,
                        input logic st, input logic we, input int wi, input logic [DW-1:0] wd,
                        input logic ec, input logic [DW-1:0] ed, input logic ev, input int es,
                        input logic ee);
        exp_t e;
        @(negedge Clock);
        Reset_n = r;
        mode    = m;
        sel_rg1 = SW'(a);
        sel_md  = SW'(b);
        sel_rg2 = SW'(c);
        stall   = st;
        wb_en   = we;
        wb_idx  = SW'(wi);
        wb_data = wd;
        err_clr = ec;
        e.data  = ed;
        e.valid = ev;
        e.src   = SW'(es);
        e.err   = ee;
        exp_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < int'(NS); i++) begin
            src_data[i*DW +: DW] = 16'h1100 + 16'(i);
        end
        src_data[5*DW +: DW]  = 16'hA5A5;
        src_data[7*DW +: DW]  = 16'h0001;
        src_data[12*DW +: DW] = 16'h1234;
        src_data[20*DW +: DW] = 16'h00FF;
        Reset_n = 1'b0;
        mode    = 2'd0;
        sel_rg1 = '0;
        sel_md  = '0;
        sel_rg2 = '0;
        stall   = 1'b0;
        wb_en   = 1'b0;
        wb_idx  = '0;
        wb_data = '0;
        err_clr = 1'b0;

`ifdef BUS_MUX_PIPE_EN
        //   rst mode rg1 md rg2 stl we wi wdata   clr  exp_data vld src err
        step(0, 1, 20, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
        step(0, 1, 20, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
        step(1, 1, 20, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h00FF, 1, 20, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h00FF, 0, 20, 0);
        step(1, 1,  5, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h00FF, 0, 20, 0);
        step(1, 1,  7, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h00FF, 0, 20, 0);
        step(1, 1,  7, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h00FF, 0, 20, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'hA5A5, 1,  5, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'hA5A5, 0,  5, 0);
        step(1, 3,  0, 0, 16, 0, 0, 0, 16'h0000, 0, 16'hA5A5, 0,  5, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'hA5A5, 0,  5, 1);
        step(1, 1,  7, 0, 0,  0, 1, 7, 16'hBEEF, 0, 16'hA5A5, 0,  5, 1);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 1, 16'hBEEF, 1,  7, 0);
        step(1, 1,  3, 0, 0,  0, 0, 0, 16'h0000, 0, 16'hBEEF, 0,  7, 0);
        step(0, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
`else
        //   rst mode rg1 md rg2 stl we wi wdata   clr  exp_data vld src err
        step(0, 1,  3, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
        step(0, 1,  3, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
        step(1, 1,  3, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h1103, 1,  3, 0);
        step(1, 2,  0, 5, 0,  0, 0, 0, 16'h0000, 0, 16'hA5A5, 1,  5, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'hA5A5, 0,  5, 0);
        step(1, 1, 12, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h1234, 1, 12, 0);
        step(1, 3,  0, 0, 16, 0, 0, 0, 16'h0000, 0, 16'h1234, 0, 12, 1);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 1, 16'h1234, 0, 12, 0);
        step(1, 3,  0, 0, 16, 0, 0, 0, 16'h0000, 0, 16'h1234, 0, 12, 1);
        step(1, 3,  0, 0, 17, 0, 0, 0, 16'h0000, 1, 16'h1234, 0, 12, 1);
        step(1, 1,  7, 0, 0,  0, 1, 7, 16'hBEEF, 0, 16'hBEEF, 1,  7, 1);
        step(1, 1,  7, 0, 0,  0, 1, 8, 16'hBEEF, 0, 16'h0001, 1,  7, 1);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 1, 16'h0001, 0,  7, 0);
        step(1, 1,  1, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h1101, 1,  1, 0);
        step(1, 1,  2, 0, 0,  1, 0, 0, 16'h0000, 0, 16'h1101, 1,  1, 0);
        step(1, 1,  2, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h1102, 1,  2, 0);
        step(1, 1,  3, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h1103, 1,  3, 0);
        step(1, 2,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h1103, 0,  3, 1);
        step(1, 0,  0, 0, 0,  1, 0, 0, 16'h0000, 1, 16'h1103, 0,  3, 1);
        step(1, 1, 21, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h1115, 1, 21, 1);
        step(1, 3,  0, 0, 31, 0, 0, 0, 16'h0000, 0, 16'h1115, 0, 21, 1);
        step(1, 3,  0, 0, 18, 0, 1,18, 16'h5555, 0, 16'h5555, 1, 18, 1);
        step(0, 1,  3, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
        step(1, 0,  0, 0, 0,  0, 0, 0, 16'h0000, 0, 16'h0000, 0,  0, 0);
`endif

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(posedge Clock);
            #2;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
